// File: rtl/ram_param_clr.sv
// Parameterised single-port RAM with a built-in clear engine and a sticky lost-write flag.
// Define RAM_PARAM_CLR_READ_REG_EN to get a registered read port (read-first, 1 cycle latency).
`timescale 1ns/1ps
module ram_param_clr #(
  parameter int               WIDTH     = 16,
  parameter int               ADDR_W    = 14,
  parameter logic [WIDTH-1:0] CLEAR_VAL = {WIDTH{1'b0}}
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [WIDTH-1:0]  in_i,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] address_i,
  input  logic              clr_i,
  output logic [WIDTH-1:0]  out_o,
  output logic              busy_o,
  output logic              lost_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;

  localparam logic [ADDR_W-1:0] LAST_PTR = {ADDR_W{1'b1}};

  logic [WIDTH-1:0]  mem [DEPTH];

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              lost_q, lost_d;

  logic              memWe;
  logic [ADDR_W-1:0] memAddr;
  logic [WIDTH-1:0]  memData;

  // The single write port is shared between user writes and the sweep; a clr edge never writes.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    lost_d  = lost_q;
    memWe   = 1'b0;
    memAddr = address_i;
    memData = in_i;
    if (state_q == CLEAR) begin
      if (load_i) begin
        lost_d = 1'b1;
      end
      if (clr_i) begin
        ptr_d = '0;
      end else begin
        memWe   = 1'b1;
        memAddr = ptr_q;
        memData = CLEAR_VAL;
        ptr_d   = ptr_q + 1'b1;
        if (ptr_q == LAST_PTR) begin
          state_d = IDLE;
        end
      end
    end else begin
      memWe = load_i;
      if (clr_i) begin
        state_d = CLEAR;
        ptr_d   = '0;
      end
    end
    if (rst_i) begin
      memWe = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      lost_q  <= lost_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (memWe) begin
      mem[memAddr] <= memData;
    end
  end

  assign busy_o = (state_q == CLEAR);
  assign lost_o = lost_q;

`ifdef RAM_PARAM_CLR_READ_REG_EN
  logic [WIDTH-1:0] out_q;

  // Read-first: the nonblocking memory write lands after this sample, so old data is captured.
  always_ff @(posedge clk_i) begin
    if (rst_i || (state_q == CLEAR)) begin
      out_q <= CLEAR_VAL;
    end else begin
      out_q <= mem[address_i];
    end
  end

  assign out_o = busy_o ? CLEAR_VAL : out_q;
`else
  assign out_o = busy_o ? CLEAR_VAL : mem[address_i];
`endif

endmodule

// File: tb/tb_ram_param_clr.sv
// Directed bench for ram_param_clr (ADDR_W=4, WIDTH=16, CLEAR_VAL=0): vector table plus corner sequences.
`timescale 1ns/1ps
module tb_ram_param_clr;

  logic        clk;
  logic        rst;
  logic [15:0] dataIn;
  logic        load;
  logic [3:0]  addr;
  logic        clr;
  logic [15:0] dataOut;
  logic        busy;
  logic        lost;

  int vectorCount = 0;
  int missCount   = 0;

  typedef struct {
    logic        rst;
    logic        load;
    logic        clr;
    logic [3:0]  addr;
    logic [15:0] data;
    logic        expBusy;
    logic        expLost;
    logic [15:0] expOut;
  } vec_t;

  vec_t vecs[$];

  ram_param_clr #(
    .WIDTH    (16),
    .ADDR_W   (4),
    .CLEAR_VAL(16'h0000)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .in_i     (dataIn),
    .load_i   (load),
    .address_i(addr),
    .clr_i    (clr),
    .out_o    (dataOut),
    .busy_o   (busy),
    .lost_o   (lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic r, input logic ld, input logic c,
                               input logic [3:0] a, input logic [15:0] d);
    rst    = r;
    load   = ld;
    clr    = c;
    addr   = a;
    dataIn = d;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectorCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic addVec(input logic r, input logic ld, input logic c, input logic [3:0] a,
                        input logic [15:0] d, input logic eb, input logic el, input logic [15:0] eo);
    vec_t v;
    v.rst = r; v.load = ld; v.clr = c; v.addr = a; v.data = d;
    v.expBusy = eb; v.expLost = el; v.expOut = eo;
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic readWord(input logic [3:0] a, input logic [15:0] exp, input string name);
    applyStimulus(1'b0, 1'b0, 1'b0, a, 16'h0000);
`ifdef RAM_PARAM_CLR_READ_REG_EN
    tick();
`else
    #1;
`endif
    checkOutput(name, dataOut, exp);
  endtask

  task automatic writeWord(input logic [3:0] a, input logic [15:0] d);
    applyStimulus(1'b0, 1'b1, 1'b0, a, d);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, a, 16'h0000);
  endtask

  task automatic readAll(input logic [15:0] exp, input string prefix);
    for (int a = 0; a < 16; a++) begin
      readWord(4'(a), exp, $sformatf("%s mem[%0d]", prefix, a));
    end
  endtask

  // Counts edges until busy is seen low, bounded so a stuck engine still reaches the summary.
  task automatic countBusy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 64) begin
      tick();
      n++;
    end
  endtask

  initial begin
    logic [15:0] prevOut;
    logic [15:0] expOut;
    int          n;
    int          total;

    applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 16'h0000);
    tick();

    // Second reset cycle, then a 16-edge sweep with a dropped write on its 4th cycle.
    addVec(1'b1, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b0, 16'h0000);
    for (int k = 1; k <= 16; k++) begin
      if (k == 4)
        addVec(1'b0, 1'b1, 1'b0, 4'd5, 16'hAAAA, 1'b1, 1'b0, 16'h0000);
      else
        addVec(1'b0, 1'b0, 1'b0, 4'd5, 16'h0000, 1'b1, (k > 4), 16'h0000);
    end
    for (int a = 0; a < 16; a++) begin
      addVec(1'b0, 1'b0, 1'b0, 4'(a), 16'h0000, 1'b0, 1'b1, 16'h0000);
    end
    addVec(1'b0, 1'b1, 1'b0, 4'd3,  16'hBEEF, 1'b0, 1'b1, 16'h0000);
    addVec(1'b0, 1'b1, 1'b0, 4'd15, 16'h1234, 1'b0, 1'b1, 16'h0000);
    addVec(1'b0, 1'b0, 1'b0, 4'd3,  16'h0000, 1'b0, 1'b1, 16'hBEEF);
    addVec(1'b0, 1'b0, 1'b0, 4'd15, 16'h0000, 1'b0, 1'b1, 16'h1234);
    addVec(1'b0, 1'b0, 1'b0, 4'd0,  16'h0000, 1'b0, 1'b1, 16'h0000);
    addVec(1'b0, 1'b1, 1'b0, 4'd3,  16'hCAFE, 1'b0, 1'b1, 16'hBEEF);
    addVec(1'b0, 1'b0, 1'b0, 4'd3,  16'h0000, 1'b0, 1'b1, 16'hCAFE);
    addVec(1'b0, 1'b0, 1'b0, 4'd0,  16'h0000, 1'b0, 1'b1, 16'h0000);

    // In registered mode the visible word is whatever the previous cycle addressed.
    prevOut = 16'h0000;
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].load, vecs[i].clr, vecs[i].addr, vecs[i].data);
      #1;
`ifdef RAM_PARAM_CLR_READ_REG_EN
      expOut = vecs[i].expBusy ? 16'h0000 : prevOut;
`else
      expOut = vecs[i].expOut;
`endif
      prevOut = vecs[i].expOut;
      checkOutput($sformatf("vec%0d busy", i), {15'b0, busy}, {15'b0, vecs[i].expBusy});
      checkOutput($sformatf("vec%0d lost", i), {15'b0, lost}, {15'b0, vecs[i].expLost});
      checkOutput($sformatf("vec%0d out", i), dataOut, expOut);
      tick();
    end

    // Clear request with a simultaneous write to a pre-filled memory.
    for (int a = 0; a < 16; a++) begin
      writeWord(4'(a), 16'hFFFF);
    end
    readWord(4'd9, 16'hFFFF, "fill mem[9]");
    readWord(4'd7, 16'hFFFF, "fill mem[7]");
    applyStimulus(1'b0, 1'b1, 1'b1, 4'd7, 16'h5555);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd7, 16'h0000);
    #1;
    checkOutput("clrreq busy", {15'b0, busy}, 16'h0001);
    checkOutput("clrreq out while busy", dataOut, 16'h0000);
    countBusy(n);
    checkOutput("clrreq busy length", 16'(n), 16'd16);
    readAll(16'h0000, "clrreq");
    checkOutput("clrreq lost still set", {15'b0, lost}, 16'h0001);

    // Restart the sweep on its 10th cycle.
    for (int a = 0; a < 16; a++) begin
      writeWord(4'(a), 16'(16'h1111 * (a + 1)));
    end
    readWord(4'd4, 16'h5555, "pattern mem[4]");
    applyStimulus(1'b0, 1'b0, 1'b1, 4'd0, 16'h0000);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 16'h0000);
    total = 0;
    repeat (9) begin
      tick();
      total++;
    end
    checkOutput("restart busy before pulse", {15'b0, busy}, 16'h0001);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'd0, 16'h0000);
    tick();
    total++;
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 16'h0000);
    countBusy(n);
    checkOutput("restart tail length", 16'(n), 16'd16);
    checkOutput("restart total length", 16'(total + n), 16'd26);
    readAll(16'h0000, "restart");

    // Reset while a write is presented in IDLE.
    applyStimulus(1'b1, 1'b1, 1'b0, 4'd2, 16'h0F0F);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd2, 16'h0000);
    #1;
    checkOutput("rst busy", {15'b0, busy}, 16'h0001);
    checkOutput("rst lost cleared", {15'b0, lost}, 16'h0000);
    checkOutput("rst out", dataOut, 16'h0000);
    countBusy(n);
    checkOutput("rst sweep length", 16'(n), 16'd16);
    writeWord(4'd6, 16'h7777);
    readWord(4'd2, 16'h0000, "rst mem[2]");
    readWord(4'd6, 16'h7777, "first usable write mem[6]");
    checkOutput("rst lost stays clear", {15'b0, lost}, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule

// File: doc/ram_param_clr.md
# ram_param_clr

Parameterised successor to the fixed 16K×16 Hack data RAM. Width and depth are set by parameters. A built-in clear engine sweeps every word to a known value after reset or on request. A sticky flag reports writes dropped while the clear runs. It replaces the fixed RAM16K and RAM8/64/512/4K tree wherever the CPU data memory or a scratch buffer needs a deterministic power-up state.

## Interface
- WIDTH, 16, data word width in bits
- ADDR_W, 14, address width; DEPTH = 2**ADDR_W words (derived, not overridable)
- CLEAR_VAL, {WIDTH{1'b0}}, value written to every word by the clear engine

- CLK  in  1  clock; all state changes on rising edge
- RST  in  1  reset; one clock, reset is synchronous and active-high
- in  in  WIDTH  write data
- load  in  1  write enable
- address  in  ADDR_W  read/write address
- clr  in  1  request a full clear sweep without reset
- out  out  WIDTH  read data
- busy  out  1  clear engine active; writes ignored
- lost  out  1  sticky: a load was ignored because busy was high

## Operation
- FSM has two states, IDLE and CLEAR. A clear pointer ptr (ADDR_W bits) runs the sweep.
- Edge with RST=1 (priority over everything):
  - state<=CLEAR, ptr<=0, lost<=0.
  - No memory write.
  - Holding RST high keeps ptr at 0.
- CLEAR, RST=0:
  - Each edge writes CLEAR_VAL to mem[ptr], then ptr<=ptr+1.
  - The edge that writes ptr=DEPTH-1 moves state to IDLE; ptr wraps to 0.
- clr=1 in IDLE: next edge state<=CLEAR, ptr<=0; no memory write on that edge.
- clr=1 in CLEAR: ptr<=0 (sweep restarts); no write on that edge.
- IDLE, load=1, clr=0: mem[address]<=in at the edge.
- IDLE, load=1, clr=1: the write is performed, then CLEAR is entered. The written word is later overwritten by the sweep.
- load=1 while busy=1 (RST=0): write discarded, lost<=1.
- lost clears only on RST.
- busy = (state==CLEAR). It is a combinational decode of a registered state.
- While busy=1, out = CLEAR_VAL regardless of address.
- Addresses are always in range: DEPTH is an exact power of two, so there is no out-of-range case.

## Timing
- Reset values: state CLEAR, busy=1, lost=0, out=CLEAR_VAL, ptr=0.
- Clear duration: busy stays high for exactly DEPTH cycles after the first edge with RST=0 (or after the edge accepting clr). It drops after the DEPTH-th edge.
- Write latency: 1 edge.
- Default read, macro undefined: out = mem[address] combinationally, as in the Hack RAM.
  - Read during write to the same address shows old data before the edge and new data after it.
- First usable cycle: the cycle in which busy=0 is sampled. A load in that cycle is accepted.

## Configuration
- RAM_PARAM_CLR_READ_REG_EN
  - Defined:
    - out is a register loaded at every edge with mem[address] using read-first semantics (old data on same-address write). Read latency is 1 cycle.
    - out is forced to CLEAR_VAL on the RST edge and on every edge while in CLEAR.
    - The first registered read appears one edge after busy falls.
  - Undefined: asynchronous combinational read as described under Operation. This is intended for the single-cycle Hack CPU.

## Test plan
All scenarios use ADDR_W=4, WIDTH=16, CLEAR_VAL=16'h0000.
- Reset sweep: hold RST for 2 cycles, then release.
  - busy=1 for exactly 16 cycles, then 0.
  - Afterwards, reading addresses 0..15 returns 16'h0000.
- Write/read: after the clear, write 16'hBEEF@3 and 16'h1234@15, then read 3, 15, 0.
  - Returns BEEF, 1234, 0000.
  - Registered mode: each value appears one cycle later.
- Dropped write: load=1 with in=16'hAAAA@5 during cycle 4 of the sweep.
  - lost=1 and stays 1.
  - After busy falls, mem[5]=0000.
  - lost returns to 0 only after RST.
- Clear request: fill all words with 16'hFFFF, then pulse clr together with load=1, in=16'h5555@7.
  - busy high for 16 cycles.
  - All words read 0000, including address 7.
- Restart mid-sweep: pulse clr at sweep cycle 10.
  - busy stays high for 16 further cycles (26 total).
  - Final memory is all 0000.
- Reset mid-operation: assert RST while writing 16'h0F0F@2 in IDLE.
  - Write suppressed, sweep restarts, lost=0.
  - After busy falls, mem[2]=0000.
